// File: rtl/voxel_fetch_arbiter.sv
// rtl/voxel_fetch_arbiter.sv - round-robin arbiter sharing one voxel RAM read port
// Grants one requester per cycle, issues a registered read and routes the word back by ID.
module voxel_fetch_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 64,
   parameter int MEM_LATENCY = 2,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_read_en,
   input  logic [DATA_W-1:0]         mem_data,
   input  logic                      hold,
   output logic                      idle
);

   logic [ID_W-1:0]                    rr_ptr_q, rr_ptr_d;
   logic                               mem_read_en_q, mem_read_en_d;
   logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
   logic [ID_W-1:0]                    issue_id_q, issue_id_d;
   logic [MEM_LATENCY-1:0]             pipe_vld_q, pipe_vld_d;
   logic [MEM_LATENCY-1:0][ID_W-1:0]   pipe_id_q, pipe_id_d;
   logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]                  rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    idx;
   logic [ID_W:0]      sum;
   logic               found;
   logic               accept;

   // Search upward from rr_ptr; the first valid requester wins.
   always_comb begin
      found  = 1'b0;
      win_id = '0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
         end
         idx = sum[ID_W-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
      grant = '0;
      if (found && !hold && rst_n) begin
         grant[win_id] = 1'b1;
      end
   end

   assign accept = |grant;

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      mem_read_en_d = accept;
      mem_addr_d    = mem_addr_q;
      issue_id_d    = issue_id_q;
      if (accept) begin
         rr_ptr_d   = (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
         mem_addr_d = req_addr[win_id*ADDR_W +: ADDR_W];
         issue_id_d = win_id;
      end
   end

   // The ID pipe is entered while the strobe is on the memory bus, so its tail
   // lines up with the cycle in which mem_data is valid.
   always_comb begin
      pipe_vld_d    = '0;
      pipe_id_d     = '0;
      pipe_vld_d[0] = mem_read_en_q;
      pipe_id_d[0]  = issue_id_q;
      for (int k = 1; k < MEM_LATENCY; k++) begin
         pipe_vld_d[k] = pipe_vld_q[k-1];
         pipe_id_d[k]  = pipe_id_q[k-1];
      end
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      if (pipe_vld_q[MEM_LATENCY-1]) begin
         rsp_valid_d[pipe_id_q[MEM_LATENCY-1]] = 1'b1;
         rsp_data_d                            = mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q      <= '0;
         mem_read_en_q <= 1'b0;
         mem_addr_q    <= '0;
         issue_id_q    <= '0;
         pipe_vld_q    <= '0;
         pipe_id_q     <= '0;
         rsp_valid_q   <= '0;
         rsp_data_q    <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         mem_read_en_q <= mem_read_en_d;
         mem_addr_q    <= mem_addr_d;
         issue_id_q    <= issue_id_d;
         pipe_vld_q    <= pipe_vld_d;
         pipe_id_q     <= pipe_id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
      end
   end

   assign req_ready   = grant;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign mem_addr    = mem_addr_q;
   assign mem_read_en = mem_read_en_q;
   assign idle        = !accept && !mem_read_en_q && !(|pipe_vld_q) && !(|rsp_valid_q);

endmodule

// File: tb/tb_voxel_fetch_arbiter.sv
// tb/tb_voxel_fetch_arbiter.sv - bench for voxel_fetch_arbiter
// Instance 0 uses MEM_LATENCY=2 for directed tests; instances 1 and 2 use 1 and 5 for random traffic.
module tb_voxel_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rv [3];
   logic [71:0] ra [3];
   logic        hd [3];
   logic [3:0]  rdy [3];
   logic [3:0]  rspv [3];
   logic [63:0] rspd [3];
   logic [63:0] mdata [3];
   logic [17:0] maddr [3];
   logic        mren [3];
   logic        idl [3];
   logic [17:0] dl [3][8];

   int npass = 0;
   int ntotal = 0;

   always #5 clk = ~clk;

   voxel_fetch_arbiter #(.NUM_REQ(4), .ADDR_W(18), .DATA_W(64), .MEM_LATENCY(2)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_addr(ra[0]), .req_ready(rdy[0]),
      .rsp_valid(rspv[0]), .rsp_data(rspd[0]), .mem_addr(maddr[0]), .mem_read_en(mren[0]),
      .mem_data(mdata[0]), .hold(hd[0]), .idle(idl[0]));

   voxel_fetch_arbiter #(.NUM_REQ(4), .ADDR_W(18), .DATA_W(64), .MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_addr(ra[1]), .req_ready(rdy[1]),
      .rsp_valid(rspv[1]), .rsp_data(rspd[1]), .mem_addr(maddr[1]), .mem_read_en(mren[1]),
      .mem_data(mdata[1]), .hold(hd[1]), .idle(idl[1]));

   voxel_fetch_arbiter #(.NUM_REQ(4), .ADDR_W(18), .DATA_W(64), .MEM_LATENCY(5)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_addr(ra[2]), .req_ready(rdy[2]),
      .rsp_valid(rspv[2]), .rsp_data(rspd[2]), .mem_addr(maddr[2]), .mem_read_en(mren[2]),
      .mem_data(mdata[2]), .hold(hd[2]), .idle(idl[2]));

   // Memory model: word = {46'h0, address}, delivered LATENCY cycles after the strobe.
   always @(posedge clk) begin
      for (int g = 0; g < 3; g++) begin
         dl[g][0] <= maddr[g];
         for (int k = 1; k < 8; k++) dl[g][k] <= dl[g][k-1];
      end
   end
   assign mdata[0] = {46'h0, dl[0][1]};
   assign mdata[1] = {46'h0, dl[1][0]};
   assign mdata[2] = {46'h0, dl[2][4]};

   typedef struct {
      logic [3:0]  v;
      logic        h;
      logic [3:0]  rdy;
      logic        mren;
      logic [17:0] maddr;
   } vec_t;

   vec_t        tbl [14];
   logic [17:0] a0 [4];
   logic [17:0] sb [12][$];
   logic [17:0] exp_a;
   logic [3:0]  acc [3];
   int          wt [3][4];
   int          rid;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      a0[0] = 18'h100; a0[1] = 18'h111; a0[2] = 18'h122; a0[3] = 18'h133;
      tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 18'h000};
      tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 18'h000};
      tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 18'h100};
      tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b1, 18'h111};
      tbl[4]  = '{4'b0001, 1'b0, 4'b0001, 1'b0, 18'h111};
      tbl[5]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 18'h100};
      tbl[6]  = '{4'b1001, 1'b0, 4'b0001, 1'b1, 18'h133};
      tbl[7]  = '{4'b0110, 1'b1, 4'b0000, 1'b1, 18'h100};
      tbl[8]  = '{4'b0110, 1'b0, 4'b0010, 1'b0, 18'h100};
      tbl[9]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 18'h111};
      tbl[10] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 18'h122};
      tbl[11] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 18'h133};
      tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 18'h111};
      tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 18'h111};

      rst_n = 1'b0;
      for (int g = 0; g < 3; g++) begin
         rv[g] = '0; hd[g] = 1'b0; ra[g] = '0;
         for (int i = 0; i < 4; i++) wt[g][i] = 0;
      end
      ra[0] = {18'h133, 18'h122, 18'h111, 18'h100};
      rv[0] = 4'b1111;
      #12;
      chk("rst_ready", rdy[0], 4'b0000);
      chk("rst_idle", idl[0], 1'b1);
      chk("rst_mren", mren[0], 1'b0);
      chk("rst_maddr", maddr[0], 18'h0);
      chk("rst_rspv", rspv[0], 4'b0000);
      chk("rst_rspd", rspd[0], 64'h0);
      rv[0] = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Arbitration vector table
      for (int r = 0; r < 14; r++) begin
         tick();
         rv[0] = tbl[r].v;
         hd[0] = tbl[r].h;
         smp();
         chk($sformatf("tbl%0d_ready", r), rdy[0], tbl[r].rdy);
         chk($sformatf("tbl%0d_mren", r), mren[0], tbl[r].mren);
         chk($sformatf("tbl%0d_maddr", r), maddr[0], tbl[r].maddr);
      end
      repeat (8) tick();
      smp();
      chk("drain_idle", idl[0], 1'b1);

      // Single request from requester 2
      ra[0][36 +: 18] = 18'h00123;
      tick(); rv[0] = 4'b0100; smp();
      chk("single_ready", rdy[0], 4'b0100);
      chk("single_idle_busy", idl[0], 1'b0);
      tick(); rv[0] = 4'b0000; smp();
      chk("single_mren", mren[0], 1'b1);
      chk("single_maddr", maddr[0], 18'h00123);
      tick(); smp(); chk("single_rspv_h2", rspv[0], 4'b0000);
      tick(); smp(); chk("single_rspv_h3", rspv[0], 4'b0000);
      tick(); smp();
      chk("single_rspv_h4", rspv[0], 4'b0100);
      chk("single_rspd_h4", rspd[0], 64'h123);
      chk("single_idle_h4", idl[0], 1'b0);
      tick(); smp();
      chk("single_idle_h5", idl[0], 1'b1);
      chk("single_rspv_h5", rspv[0], 4'b0000);
      ra[0][36 +: 18] = 18'h122;

      // Reset while two reads are in flight
      tick(); rv[0] = 4'b0011; smp();
      chk("mid_grant0", rdy[0], 4'b0001);
      tick(); rv[0] = 4'b0010; smp();
      chk("mid_grant1", rdy[0], 4'b0010);
      tick(); rv[0] = 4'b0110; smp();
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_mren", mren[0], 1'b0);
      chk("mid_rst_maddr", maddr[0], 18'h0);
      chk("mid_rst_rspv", rspv[0], 4'b0000);
      chk("mid_rst_ready", rdy[0], 4'b0000);
      chk("mid_rst_idle", idl[0], 1'b1);
      rv[0] = 4'b0000;
      #1 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(); smp();
         chk($sformatf("mid_no_rsp%0d", c), rspv[0], 4'b0000);
      end
      tick(); rv[0] = 4'b0110; smp();
      chk("mid_lowest", rdy[0], 4'b0010);
      tick(); rv[0] = 4'b1100; smp();
      chk("wrap_pre2", rdy[0], 4'b0100);
      tick(); rv[0] = 4'b1000; smp();
      chk("wrap_pre3", rdy[0], 4'b1000);
      tick(); rv[0] = 4'b0000;
      repeat (6) tick();

      // All four valid for 8 cycles
      for (int c = 0; c < 12; c++) begin
         tick();
         rv[0] = (c < 8) ? 4'b1111 : 4'b0000;
         smp();
         if (c < 8) chk($sformatf("rr_grant%0d", c), rdy[0], 4'b0001 << (c % 4));
         if (c >= 4) begin
            chk($sformatf("rr_rspv%0d", c), rspv[0], 4'b0001 << ((c - 4) % 4));
            chk($sformatf("rr_rspd%0d", c), rspd[0], {46'h0, a0[(c - 4) % 4]});
         end
      end
      repeat (4) tick();

      // Requester 0 continuous, requester 3 joins at cycle 5
      for (int c = 0; c < 11; c++) begin
         tick();
         rv[0] = (c < 5) ? 4'b0001 : 4'b1001;
         smp();
         chk($sformatf("join_grant%0d", c), rdy[0],
             (c < 5) ? 4'b0001 : (((c - 5) % 2 == 0) ? 4'b1000 : 4'b0001));
      end
      tick(); rv[0] = 4'b0000;
      repeat (6) tick();

      // Hold with in-flight responses
      tick(); rv[0] = 4'b0001; smp(); chk("hold_pre0", rdy[0], 4'b0001);
      tick(); rv[0] = 4'b0001; smp(); chk("hold_pre1", rdy[0], 4'b0001);
      for (int c = 2; c < 5; c++) begin
         tick(); rv[0] = 4'b0110; hd[0] = 1'b1; smp();
         chk($sformatf("hold_ready%0d", c), rdy[0], 4'b0000);
         if (c == 4) begin
            chk("hold_rspv_during", rspv[0], 4'b0001);
            chk("hold_rspd_during", rspd[0], 64'h100);
         end
      end
      tick(); hd[0] = 1'b0; smp();
      chk("hold_release", rdy[0], 4'b0010);
      chk("hold_rspv_after", rspv[0], 4'b0001);
      tick(); rv[0] = 4'b0100; smp();
      chk("hold_second", rdy[0], 4'b0100);
      tick(); rv[0] = 4'b0000;
      repeat (6) tick();

      // Random traffic on the MEM_LATENCY=1 and MEM_LATENCY=5 instances
      acc[1] = '0; acc[2] = '0;
      for (int cyc = 0; cyc < 2020; cyc++) begin
         tick();
         for (int g = 1; g < 3; g++) begin
            rv[g] = rv[g] & ~acc[g];
            if (cyc < 2000) begin
               for (int i = 0; i < 4; i++) begin
                  if (!rv[g][i] && ($urandom_range(0, 1) == 1)) begin
                     rv[g][i] = 1'b1;
                     ra[g][i*18 +: 18] = 18'($urandom);
                  end
               end
               hd[g] = ($urandom_range(0, 9) == 0);
            end else begin
               hd[g] = 1'b0;
            end
         end
         smp();
         for (int g = 1; g < 3; g++) begin
            acc[g] = rv[g] & rdy[g];
            for (int i = 0; i < 4; i++) begin
               if (acc[g][i]) sb[g*4+i].push_back(ra[g][i*18 +: 18]);
               if (rv[g][i] && !hd[g]) begin
                  if (acc[g][i]) wt[g][i] = 0;
                  else wt[g][i]++;
                  chk($sformatf("rnd%0d_wait_req%0d", g, i), wt[g][i] <= 3, 1'b1);
               end
            end
            if (rspv[g] != 4'b0000) begin
               chk($sformatf("rnd%0d_rsp_onehot", g), $onehot(rspv[g]), 1'b1);
               rid = 0;
               for (int i = 0; i < 4; i++) if (rspv[g][i]) rid = i;
               if (sb[g*4+rid].size() == 0) begin
                  chk($sformatf("rnd%0d_spurious_req%0d", g, rid), rspv[g], 4'b0000);
               end else begin
                  exp_a = sb[g*4+rid].pop_front();
                  chk($sformatf("rnd%0d_data_req%0d", g, rid), rspd[g], {46'h0, exp_a});
               end
            end
         end
      end
      for (int q = 4; q < 12; q++) chk($sformatf("rnd_left_q%0d", q), sb[q].size(), 0);
      chk("rnd1_idle_end", idl[1], 1'b1);
      chk("rnd2_idle_end", idl[2], 1'b1);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/voxel_fetch_arbiter.md
# voxel_fetch_arbiter

Shares the single read port of the voxel memory (18-bit address, 64-bit word) between `NUM_REQ` trilinear interpolator instances. Each cycle it accepts at most one read request by round-robin, issues it to memory as a registered read, and tracks requester IDs through a fixed-latency pipeline. Each returning word is routed back to the requester that issued it. It sits between the interpolator array and the voxel RAM in the volume-rendering datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (legal range 2..8).
- `ADDR_W`, 18: voxel address width.
- `DATA_W`, 64: voxel word width.
- `MEM_LATENCY`, 2: cycles from `mem_read_en` high to valid `mem_data` (legal range 1..8).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester read request.
- `req_addr` in NUM_REQ*ADDR_W: packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- `req_ready` out NUM_REQ: one-hot grant, combinational.
- `rsp_valid` out NUM_REQ: one-hot, registered; the response word belongs to the flagged requester.
- `rsp_data` out DATA_W: registered response word, broadcast to all requesters.
- `mem_addr` out ADDR_W: registered read address.
- `mem_read_en` out 1: registered read strobe.
- `mem_data` in DATA_W: memory read data.
- `hold` in 1: when high, no new grants are made.
- `idle` out 1: high when nothing is issued or in flight.

## Operation
- Arbitration:
  - Candidates are the requesters with `req_valid[i]`=1.
  - The winner is the first candidate searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]`=1 in the same cycle. It is all-zero when `hold`=1 or there are no candidates.
  - `req_ready` never depends on itself or on `rsp_*`.
- Handshake: a request is accepted in a cycle where `req_valid[i] && req_ready[i]`.
  - A requester must keep `req_valid` and `req_addr` stable until accepted.
  - A requester may drop `req_valid` before acceptance without side effects.
- On acceptance:
  - Next cycle: `mem_read_en`=1 and `mem_addr`=accepted address.
  - `rr_ptr` ← (winner+1) mod NUM_REQ.
  - Otherwise `mem_read_en`=0, `mem_addr` holds its last value, and `rr_ptr` is unchanged.
- ID pipeline: a MEM_LATENCY-deep shift register of {valid, id[$clog2(NUM_REQ)-1:0]}, advanced every cycle.
  - It is loaded with {1, winner} at the point `mem_read_en` is issued.
  - At the output stage, if the entry is valid: `rsp_data` ← `mem_data` and `rsp_valid[id]` ← 1 on the next edge.
- `rsp_data` holds its last value when `rsp_valid` is zero.
- `idle` = no request accepted this cycle AND `mem_read_en`=0 AND no valid entry in the ID pipeline AND `rsp_valid`=0. It is combinational.
- Throughput: one accepted request per cycle, sustained. There is no backpressure on responses; requesters must always sink `rsp_valid`.
- `hold` blocks new grants only. In-flight reads always complete and return.

## Timing
- Reset values, all asynchronous on `rst_n` low:
  - `rr_ptr`=0 (requester 0 has top priority after reset).
  - `mem_read_en`=0, `mem_addr`=0.
  - `rsp_valid`=0, `rsp_data`=0.
  - All ID pipeline entries invalid.
  - Therefore `idle`=1 and `req_ready`=0 while `rst_n` is low.
- Latency, with acceptance in cycle H:
  - `mem_read_en` high in H+1.
  - `mem_data` sampled in cycle H+1+MEM_LATENCY.
  - `rsp_valid` high in H+2+MEM_LATENCY. With the default MEM_LATENCY, that is 4 cycles after acceptance.
- Back-to-back acceptances in H and H+1 give responses in consecutive cycles, in issue order.
- Reset mid-flight: all in-flight reads are discarded. No `rsp_valid` is produced for them after reset release.
- `hold` rising in the same cycle as a candidate: no grant that cycle. `hold` falling: a grant is possible in that same cycle.
- Wrap-around: after requester NUM_REQ-1 wins, `rr_ptr`=0.
- Single candidate: it wins every cycle regardless of `rr_ptr`.

## Test plan
- Reset, then requester 2 requests addr 0x00123 in cycle H, with memory modelling data = {46'h0, addr}:
  - `mem_read_en`/`mem_addr`=0x00123 in H+1.
  - `rsp_valid`=4'b0100, `rsp_data`=0x123 in H+4.
  - `idle` returns to 1 in H+5.
- All 4 requesters hold `req_valid` continuously for 8 cycles:
  - Grants go 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order on consecutive cycles with matching data.
- Requester 0 requests continuously and requester 3 raises `req_valid` at cycle 5:
  - Requester 3 is granted within 1 cycle of raising.
  - Grants then alternate 0,3,0,3.
- `hold`=1 for 3 cycles while requesters 1 and 2 are valid:
  - `req_ready`=0 throughout; earlier in-flight responses still arrive.
  - After release, requester 1 is granted first, then requester 2.
- `rst_n` pulsed low while 2 reads are in flight:
  - All outputs go to reset values immediately.
  - No `rsp_valid` occurs in the following MEM_LATENCY+2 cycles.
  - The next grant goes to the lowest-index valid requester.
- Random traffic, 2000 cycles, MEM_LATENCY=1 and MEM_LATENCY=5:
  - A scoreboard checks per-requester in-order delivery and correct data.
  - No requester waits more than NUM_REQ-1 cycles while continuously valid and `hold`=0.
